// File: rtl/usb_reg_sequencer.sv
// usb_reg_sequencer: command-driven master for the CW305 USB parallel register bus.
// Each accepted command becomes a byte-wise write burst, read burst, busy poll
// or trigger pulse. Every bus strobe, address and response output is registered.
// Build option: define USB_SEQ_TRIGGER_EN to implement the TRIG op and the usb_trigger
// pulse generator. Without it, usb_trigger is tied low and op 3 completes with rsp_error.
module usb_reg_sequencer #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pREG_BITS     = 6,
    parameter int pMAX_BYTES    = 32,
    parameter int pPOLL_MAX     = 1024,
    parameter int pTRIG_CYCLES  = 10
) (
    input  logic                              usb_clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [1:0]                        cmd_block,
    input  logic [pREG_BITS-1:0]              cmd_addr,
    input  logic [$clog2(pMAX_BYTES+1)-1:0]   cmd_nbytes,
    input  logic [8*pMAX_BYTES-1:0]           cmd_wdata,
    output logic                              rsp_valid,
    output logic [8*pMAX_BYTES-1:0]           rsp_rdata,
    output logic                              rsp_error,
    output logic                              rsp_timeout,
    output logic [pADDR_WIDTH-1:0]            usb_addr,
    output logic [7:0]                        usb_wdata,
    output logic                              usb_data_oe,
    input  logic [7:0]                        usb_rdata,
    output logic                              usb_rdn,
    output logic                              usb_wrn,
    output logic                              usb_cen,
    output logic                              usb_trigger
);
    localparam int NBW   = $clog2(pMAX_BYTES + 1);
    localparam int PCW   = $clog2(pPOLL_MAX + 1);
    localparam int NSLOT = 2 ** NBW;
    localparam logic [NBW-1:0] MAX_NB     = NBW'(pMAX_BYTES);
    localparam logic [PCW-1:0] POLL_LIMIT = PCW'(pPOLL_MAX);
    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd2;

    typedef enum logic [3:0] {
        IDLE, W_SETUP, W_CEN, W_CENH, W_REL, W_GAP,
        R_SETUP, R_LOW1, R_LOW2, R_SAMPLE, R_REL, R_GAP1, R_GAP2,
        TRIG, DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [1:0]              r_op;
    logic [1:0]              r_block;
    logic [pREG_BITS-1:0]    r_reg;
    logic [NBW-1:0]          r_nbytes;
    logic [8*pMAX_BYTES-1:0] r_wdata;
    logic [NBW-1:0]          r_byte;
    logic [NBW-1:0]          w_byte_next;
    logic [NBW-1:0]          w_byte_inc;
    logic [PCW-1:0]          r_poll_cnt;
    logic                    w_accept;
    logic                    w_err_next;
    logic                    w_to_next;
    logic [1:0]              w_block_src;
    logic [pREG_BITS-1:0]    w_reg_src;
    logic [8*pMAX_BYTES-1:0] w_wdata_src;
    logic [7:0]              w_wbyte [NSLOT];
    logic [pADDR_WIDTH-1:0]  w_addr_next;
    logic                    r_rsp_valid, r_rsp_error, r_rsp_timeout;
    logic [pADDR_WIDTH-1:0]  r_usb_addr;
    logic [7:0]              r_usb_wdata;
    logic                    r_oe, r_rdn, r_wrn, r_cen;

    assign w_accept    = cmd_valid && (r_state == IDLE);
    assign w_byte_inc  = r_byte + NBW'(1);
    // The cycle that accepts a command must already drive its address/data, so
    // the bus values come from the command port on that edge and from the latches after.
    assign w_block_src = w_accept ? cmd_block : r_block;
    assign w_reg_src   = w_accept ? cmd_addr  : r_reg;
    assign w_wdata_src = w_accept ? cmd_wdata : r_wdata;

    // Byte lanes padded to a power of two so any byte index selects a defined lane.
    genvar gi;
    for (gi = 0; gi < NSLOT; gi++) begin : g_wlane
        if (gi < pMAX_BYTES) begin : g_live
            assign w_wbyte[gi] = w_wdata_src[8*gi +: 8];
        end else begin : g_pad
            assign w_wbyte[gi] = 8'h00;
        end
    end

`ifdef USB_SEQ_TRIGGER_EN
    localparam int TCW = $clog2(pTRIG_CYCLES + 1);
    localparam logic [TCW-1:0] TRIG_LAST = TCW'(pTRIG_CYCLES - 1);
    logic [TCW-1:0] r_trig_cnt;
    logic           r_trigger;
    logic           w_trig_last;
    assign w_trig_last = (r_trig_cnt == TRIG_LAST);
`endif

    // Bus address: {zeros, block, register, subbyte}.
    always_comb begin
        w_addr_next = '0;
        w_addr_next[pBYTECNT_SIZE-1:0] = pBYTECNT_SIZE'(w_byte_next);
        w_addr_next[pBYTECNT_SIZE +: pREG_BITS] = w_reg_src;
        w_addr_next[pBYTECNT_SIZE+pREG_BITS +: 2] = w_block_src;
    end

    // Next-state, byte index and completion status.
    always_comb begin
        w_state_next = r_state;
        w_byte_next  = r_byte;
        w_err_next   = 1'b0;
        w_to_next    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_byte_next = '0;
                    if (cmd_nbytes > MAX_NB) begin
                        w_state_next = DONE;
                        w_err_next   = 1'b1;
                    end else begin
                        case (cmd_op)
                            OP_WRITE: w_state_next = (cmd_nbytes == '0) ? DONE : W_SETUP;
                            OP_READ:  w_state_next = (cmd_nbytes == '0) ? DONE : R_SETUP;
                            OP_POLL:  w_state_next = R_SETUP;
                            default: begin
`ifdef USB_SEQ_TRIGGER_EN
                                w_state_next = TRIG;
`else
                                w_state_next = DONE;
                                w_err_next   = 1'b1;
`endif
                            end
                        endcase
                    end
                end
            end
            W_SETUP:  w_state_next = W_CEN;
            W_CEN:    w_state_next = W_CENH;
            W_CENH:   w_state_next = W_REL;
            W_REL:    w_state_next = W_GAP;
            W_GAP: begin
                if (w_byte_inc == r_nbytes) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = W_SETUP;
                    w_byte_next  = w_byte_inc;
                end
            end
            R_SETUP:  w_state_next = R_LOW1;
            R_LOW1:   w_state_next = R_LOW2;
            R_LOW2:   w_state_next = R_SAMPLE;
            R_SAMPLE: w_state_next = R_REL;
            R_REL:    w_state_next = R_GAP1;
            R_GAP1:   w_state_next = R_GAP2;
            R_GAP2: begin
                if (r_op == OP_POLL) begin
                    // Byte 0 already holds this attempt's captured status.
                    if (!rsp_rdata[0]) begin
                        w_state_next = DONE;
                    end else if (r_poll_cnt == POLL_LIMIT) begin
                        w_state_next = DONE;
                        w_to_next    = 1'b1;
                    end else begin
                        w_state_next = R_SETUP;
                    end
                end else if (w_byte_inc == r_nbytes) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = R_SETUP;
                    w_byte_next  = w_byte_inc;
                end
            end
            TRIG: begin
`ifdef USB_SEQ_TRIGGER_EN
                w_state_next = w_trig_last ? DONE : TRIG;
`else
                w_state_next = DONE;
`endif
            end
            DONE:     w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // State, byte index, poll attempts and latched command fields.
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_byte     <= '0;
            r_poll_cnt <= '0;
            r_op       <= '0;
            r_block    <= '0;
            r_reg      <= '0;
            r_nbytes   <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_state_next;
            r_byte  <= w_byte_next;
            if (w_accept) begin
                r_op       <= cmd_op;
                r_block    <= cmd_block;
                r_reg      <= cmd_addr;
                r_nbytes   <= cmd_nbytes;
                r_wdata    <= cmd_wdata;
                r_poll_cnt <= '0;
            end else if (r_state == R_SAMPLE && r_op == OP_POLL) begin
                r_poll_cnt <= r_poll_cnt + PCW'(1);
            end
        end
    end

    // Bus strobes and response flags follow the state being entered, so they are registered.
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            r_wrn         <= 1'b1;
            r_rdn         <= 1'b1;
            r_cen         <= 1'b1;
            r_oe          <= 1'b0;
            r_usb_addr    <= '0;
            r_usb_wdata   <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_wrn       <= !(w_state_next inside {W_SETUP, W_CEN, W_CENH});
            r_oe        <=  (w_state_next inside {W_SETUP, W_CEN, W_CENH});
            r_rdn       <= !(w_state_next inside {R_LOW1, R_LOW2, R_SAMPLE});
            r_cen       <= !(w_state_next inside {W_CEN, R_LOW1, R_LOW2, R_SAMPLE});
            r_rsp_valid <= (w_state_next == DONE);
            if (w_state_next == W_SETUP) begin
                r_usb_addr  <= w_addr_next;
                r_usb_wdata <= w_wbyte[w_byte_next];
            end else if (w_state_next == R_SETUP) begin
                r_usb_addr  <= w_addr_next;
            end
            if (w_state_next == DONE) begin
                r_rsp_error   <= w_err_next;
                r_rsp_timeout <= w_to_next;
            end
        end
    end

    // One capture register per response byte, loaded on the edge leaving R_SAMPLE.
    for (gi = 0; gi < pMAX_BYTES; gi++) begin : g_rd
        logic [7:0] r_rbyte;
        // Capture the bus byte for this lane; other lanes keep their old value.
        always_ff @(posedge usb_clk or posedge rst) begin
            if (rst) begin
                r_rbyte <= '0;
            end else if (r_state == R_SAMPLE && r_byte == NBW'(gi)) begin
                r_rbyte <= usb_rdata;
            end
        end
        assign rsp_rdata[8*gi +: 8] = r_rbyte;
    end

`ifdef USB_SEQ_TRIGGER_EN
    // Trigger pulse register and its high-time counter.
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            r_trigger  <= 1'b0;
            r_trig_cnt <= '0;
        end else begin
            r_trigger <= (w_state_next == TRIG);
            if (w_accept) begin
                r_trig_cnt <= '0;
            end else if (r_state == TRIG) begin
                r_trig_cnt <= r_trig_cnt + TCW'(1);
            end
        end
    end
    assign usb_trigger = r_trigger;
`else
    // Trigger length has no effect when the pulse generator is not built.
    localparam int unused_trig_cycles = pTRIG_CYCLES;
    assign usb_trigger = 1'b0;
`endif

    assign cmd_ready   = (r_state == IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_error   = r_rsp_error;
    assign rsp_timeout = r_rsp_timeout;
    assign usb_addr    = r_usb_addr;
    assign usb_wdata   = r_usb_wdata;
    assign usb_data_oe = r_oe;
    assign usb_rdn     = r_rdn;
    assign usb_wrn     = r_wrn;
    assign usb_cen     = r_cen;

endmodule

// File: tb/tb_usb_reg_sequencer.sv
`timescale 1ns/1ps

module tb_usb_reg_sequencer;
    logic         usb_clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = '0;
    logic [1:0]   cmd_block = '0;
    logic [5:0]   cmd_addr = '0;
    logic [5:0]   cmd_nbytes = '0;
    logic [255:0] cmd_wdata = '0;
    logic         rsp_valid;
    logic [255:0] rsp_rdata;
    logic         rsp_error;
    logic         rsp_timeout;
    logic [20:0]  usb_addr;
    logic [7:0]   usb_wdata;
    logic         usb_data_oe;
    logic [7:0]   usb_rdata;
    logic         usb_rdn, usb_wrn, usb_cen, usb_trigger;

    int n_asrt = 0;
    int n_fail = 0;

    usb_reg_sequencer #(
        .pADDR_WIDTH(21), .pBYTECNT_SIZE(7), .pREG_BITS(6),
        .pMAX_BYTES(32), .pPOLL_MAX(4), .pTRIG_CYCLES(10)
    ) dut (
        .usb_clk(usb_clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_block(cmd_block), .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .usb_addr(usb_addr),
        .usb_wdata(usb_wdata), .usb_data_oe(usb_data_oe), .usb_rdata(usb_rdata),
        .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_cen(usb_cen),
        .usb_trigger(usb_trigger)
    );

    always #5 usb_clk = ~usb_clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_asrt++;
        if (obs !== exp_v) begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    logic [7:0] rd_q [16];
    int         rd_idx = 0;
    assign usb_rdata = rd_q[rd_idx[3:0]];
    always @(posedge usb_rdn) rd_idx++;

    logic        mon_en = 1'b0;
    logic        prev_wrn = 1'b1, prev_rdn = 1'b1;
    int          wrn_low, rdn_low, cen_low, trig_hi, rv_cnt, wr_cnt, rd_cnt;
    logic [20:0] wr_addr [32];
    logic [7:0]  wr_data [32];
    logic [20:0] rd_addr [32];

    always @(negedge usb_clk) begin
        if (mon_en) begin
            n_asrt++;
            if ((usb_wrn | usb_rdn) !== 1'b1) begin
                n_fail++;
                $error("FAIL no_wrn_rdn_overlap: observed wrn=%b rdn=%b, expected not both low", usb_wrn, usb_rdn);
            end
            n_asrt++;
            if ((usb_data_oe & usb_wrn) !== 1'b0) begin
                n_fail++;
                $error("FAIL oe_only_while_wrn_low: observed oe=%b wrn=%b, expected oe=0 while wrn=1", usb_data_oe, usb_wrn);
            end
            if (!usb_wrn) wrn_low++;
            if (!usb_rdn) rdn_low++;
            if (!usb_cen) cen_low++;
            if (usb_trigger) trig_hi++;
            if (rsp_valid) rv_cnt++;
            if (!usb_wrn && prev_wrn && wr_cnt < 32) begin
                wr_addr[wr_cnt] = usb_addr;
                wr_data[wr_cnt] = usb_wdata;
                wr_cnt++;
            end
            if (!usb_rdn && prev_rdn && rd_cnt < 32) begin
                rd_addr[rd_cnt] = usb_addr;
                rd_cnt++;
            end
        end
        prev_wrn = usb_wrn;
        prev_rdn = usb_rdn;
    end

    task automatic clear_mon();
        wrn_low = 0; rdn_low = 0; cen_low = 0; trig_hi = 0;
        rv_cnt = 0; wr_cnt = 0; rd_cnt = 0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] blk,
                         input logic [5:0] adr, input logic [5:0] nb,
                         input logic [255:0] wd);
        @(negedge usb_clk);
        check("ready_before_cmd", cmd_ready, 1'b1);
        cmd_op = op; cmd_block = blk; cmd_addr = adr; cmd_nbytes = nb;
        cmd_wdata = wd; cmd_valid = 1'b1;
        clear_mon();
        @(posedge usb_clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge usb_clk);
            if (rsp_valid === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    logic [7:0]   exp_w [16] = '{8'h77, 8'hf3, 8'h01, 8'h9e, 8'h8d, 8'h7c, 8'h6b, 8'h5a,
                                 8'h4f, 8'h3e, 8'h2d, 8'h1c, 8'hf8, 8'h8b, 8'h27, 8'h8a};
    logic [255:0] wd16 = {128'h0, 128'h8a278bf81c2d3e4f5a6b7c8d9e01f377};

    initial begin
        int cyc;
        for (int i = 0; i < 16; i++) rd_q[i] = 8'h00;

        repeat (2) @(negedge usb_clk);
        check("rst_wrn", usb_wrn, 1'b1);
        check("rst_rdn", usb_rdn, 1'b1);
        check("rst_cen", usb_cen, 1'b1);
        check("rst_oe", usb_data_oe, 1'b0);
        check("rst_addr", usb_addr, 21'h0);
        check("rst_wdata", usb_wdata, 8'h00);
        check("rst_trig", usb_trigger, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_error", rsp_error, 1'b0);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 256'h0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        mon_en = 1'b1;

        $display("txn WRITE blk0 addr5 nbytes16");
        issue(2'd0, 2'd0, 6'd5, 6'd16, wd16);
        wait_done(cyc);
        check("wr16_done_cycle", cyc, 80);
        check("wr16_ready_at_done", cmd_ready, 1'b0);
        check("wr16_error", rsp_error, 1'b0);
        check("wr16_wrn_pulses", wr_cnt, 16);
        check("wr16_cen_low", cen_low, 16);
        check("wr16_wrn_low", wrn_low, 48);
        check("wr16_rdn_low", rdn_low, 0);
        for (int b = 0; b < 16; b++) begin
            n_asrt++;
            if (wr_addr[b] !== (21'h280 | 21'(b))) begin
                n_fail++;
                $error("FAIL wr16_addr[%0d]: observed %0h, expected %0h", b, wr_addr[b], (21'h280 | 21'(b)));
            end
            n_asrt++;
            if (wr_data[b] !== exp_w[b]) begin
                n_fail++;
                $error("FAIL wr16_data[%0d]: observed %0h, expected %0h", b, wr_data[b], exp_w[b]);
            end
        end
        @(negedge usb_clk);
        check("wr16_ready_after", cmd_ready, 1'b1);

        $display("txn READ blk1 addr6 nbytes4");
        rd_q[0] = 8'h11; rd_q[1] = 8'h22; rd_q[2] = 8'h33; rd_q[3] = 8'h44; rd_idx = 0;
        issue(2'd1, 2'd1, 6'd6, 6'd4, 256'h0);
        wait_done(cyc);
        check("rd4_done_cycle", cyc, 28);
        check("rd4_rdata", rsp_rdata, 256'h44332211);
        check("rd4_rdn_low", rdn_low, 12);
        check("rd4_cen_low", cen_low, 12);
        check("rd4_wrn_low", wrn_low, 0);
        check("rd4_addr_b0", rd_addr[0], 21'h2300);
        check("rd4_addr_b3", rd_addr[3], 21'h2303);
        check("rd4_error", rsp_error, 1'b0);

        $display("txn READ blk0 addr6 nbytes2");
        rd_q[0] = 8'h55; rd_q[1] = 8'h66; rd_idx = 0;
        issue(2'd1, 2'd0, 6'd6, 6'd2, 256'h0);
        wait_done(cyc);
        check("rd2_done_cycle", cyc, 14);
        check("rd2_rdata", rsp_rdata, 256'h44336655);

        $display("txn POLL addr7 seq 01,01,00");
        rd_q[0] = 8'h01; rd_q[1] = 8'h01; rd_q[2] = 8'h00; rd_idx = 0;
        issue(2'd2, 2'd0, 6'd7, 6'd9, 256'h0);
        wait_done(cyc);
        check("poll_done_cycle", cyc, 21);
        check("poll_rdata", rsp_rdata, 256'h44336600);
        check("poll_timeout", rsp_timeout, 1'b0);
        check("poll_error", rsp_error, 1'b0);
        check("poll_rdn_low", rdn_low, 9);
        check("poll_addr", rd_addr[2], 21'h380);

        $display("txn POLL addr7 always 01");
        for (int i = 0; i < 16; i++) rd_q[i] = 8'h01;
        rd_idx = 0;
        issue(2'd2, 2'd0, 6'd7, 6'd0, 256'h0);
        wait_done(cyc);
        check("polltmo_done_cycle", cyc, 28);
        check("polltmo_timeout", rsp_timeout, 1'b1);
        check("polltmo_rdata", rsp_rdata, 256'h44336601);
        check("polltmo_rdn_low", rdn_low, 12);
        @(negedge usb_clk);
        check("polltmo_timeout_hold", rsp_timeout, 1'b1);
        check("polltmo_valid_pulse", rsp_valid, 1'b0);

        $display("txn WRITE nbytes33 (illegal)");
        issue(2'd0, 2'd0, 6'd5, 6'd33, wd16);
        wait_done(cyc);
        check("nb33_done_cycle", cyc, 0);
        check("nb33_error", rsp_error, 1'b1);
        check("nb33_timeout_cleared", rsp_timeout, 1'b0);
        repeat (3) @(negedge usb_clk);
        check("nb33_error_hold", rsp_error, 1'b1);
        check("nb33_no_wrn", wrn_low, 0);
        check("nb33_no_cen", cen_low, 0);

        $display("txn READ nbytes0");
        issue(2'd1, 2'd0, 6'd6, 6'd0, 256'h0);
        wait_done(cyc);
        check("nb0_done_cycle", cyc, 0);
        check("nb0_error", rsp_error, 1'b0);
        repeat (3) @(negedge usb_clk);
        check("nb0_no_rdn", rdn_low, 0);

        $display("txn TRIG");
        issue(2'd3, 2'd0, 6'd0, 6'd0, 256'h0);
        wait_done(cyc);
`ifdef USB_SEQ_TRIGGER_EN
        check("trig_done_cycle", cyc, 10);
        check("trig_high_cycles", trig_hi, 10);
        check("trig_error", rsp_error, 1'b0);
`else
        check("trig_done_cycle", cyc, 0);
        check("trig_error", rsp_error, 1'b1);
        repeat (3) @(negedge usb_clk);
        check("trig_high_cycles", trig_hi, 0);
`endif

        $display("txn WRITE nbytes16 with reset at cycle 12");
        issue(2'd0, 2'd0, 6'd5, 6'd16, wd16);
        repeat (13) @(negedge usb_clk);
        check("midrst_pre_wrn", usb_wrn, 1'b0);
        check("midrst_pre_oe", usb_data_oe, 1'b1);
        check("midrst_pre_addr", usb_addr, 21'h282);
        rst = 1'b1;
        #1;
        check("midrst_wrn", usb_wrn, 1'b1);
        check("midrst_cen", usb_cen, 1'b1);
        check("midrst_oe", usb_data_oe, 1'b0);
        check("midrst_rdn", usb_rdn, 1'b1);
        check("midrst_addr", usb_addr, 21'h0);
        check("midrst_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge usb_clk);
        rst = 1'b0;
        repeat (5) @(negedge usb_clk);
        check("midrst_no_rsp_valid", rv_cnt, 0);
        check("midrst_rdata_cleared", rsp_rdata, 256'h0);

        $display("txn READ blk0 addr6 nbytes4 after reset");
        rd_q[0] = 8'h11; rd_q[1] = 8'h22; rd_q[2] = 8'h33; rd_q[3] = 8'h44; rd_idx = 0;
        issue(2'd1, 2'd0, 6'd6, 6'd4, 256'h0);
        wait_done(cyc);
        check("post_rd_done_cycle", cyc, 28);
        check("post_rd_rdata", rsp_rdata, 256'h44332211);
        check("post_rd_rdn_low", rdn_low, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
